// File: rtl/rpn_sequencer.sv
// rpn_sequencer: RPN token sequencer with a small operand stack.
//   Operand tokens are pushed onto the stack in one cycle.
//   An operator token moves the FSM to EXEC. During EXEC the two top entries
//   and the operator are presented to an external combinational calculator.
//   The result is folded back onto the stack on the EXEC clock edge.
//   Overflow, underflow and divide-by-zero put the FSM in ERR. ERR is sticky
//   until clr is asserted.
//
// Parameters
//   DATA_WIDTH   operand/result width (default 16)
//   STACK_DEPTH  number of stack entries, >= 2 (default 4)
//
// Ports
//   clk, rst                  clock and asynchronous active-high reset
//   tok_valid/tok_ready       token handshake (ready only in IDLE)
//   tok_is_op, tok_op         1 = operator (00 add, 01 sub, 10 mul, 11 div)
//   tok_data                  operand value for a push
//   calc_a, calc_b, calc_op   operands/operator to calculator (0 outside EXEC)
//   calc_result, calc_invalid calculator result and divide-by-zero flag
//   clr                       clears the sticky error (effective in ERR only)
//   top, depth                top-of-stack (0 when empty) and entry count
//   error, err_code           sticky error; 00 none, 01 ovf, 10 udf, 11 div0
//   op_count                  (only with RPN_OPCNT_EN) successful EXEC count
//
// Build option
//   RPN_OPCNT_EN  adds the 16-bit wrapping op_count output.

module rpn_sequencer #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               tok_valid,
    output logic                               tok_ready,
    input  logic                               tok_is_op,
    input  logic [1:0]                         tok_op,
    input  logic [DATA_WIDTH-1:0]              tok_data,
    output logic [DATA_WIDTH-1:0]              calc_a,
    output logic [DATA_WIDTH-1:0]              calc_b,
    output logic [1:0]                         calc_op,
    input  logic [DATA_WIDTH-1:0]              calc_result,
    input  logic                               calc_invalid,
    input  logic                               clr,
    output logic [DATA_WIDTH-1:0]              top,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               error,
`ifdef RPN_OPCNT_EN
    output logic [15:0]                        op_count,
`endif
    output logic [1:0]                         err_code
);

    localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IW = $clog2(STACK_DEPTH);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UDF  = 2'b10;
    localparam logic [1:0] ERR_DIV0 = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t                  state_q,    state_d;
    logic [DATA_WIDTH-1:0]   stack_q [STACK_DEPTH];
    logic [DATA_WIDTH-1:0]   stack_d [STACK_DEPTH];
    logic [DW-1:0]           depth_q,    depth_d;
    logic [DATA_WIDTH-1:0]   top_q,      top_d;
    logic [DATA_WIDTH-1:0]   calc_a_q,   calc_a_d;
    logic [DATA_WIDTH-1:0]   calc_b_q,   calc_b_d;
    logic [1:0]              calc_op_q,  calc_op_d;
    logic [1:0]              err_code_q, err_code_d;
    logic                    error_q,    error_d;
    logic                    tok_ready_q, tok_ready_d;

`ifdef RPN_OPCNT_EN
    logic [15:0]             op_count_q, op_count_d;
`endif

    // Stack slot indices derived from the current depth
    logic [IW-1:0] idx_push;
    logic [IW-1:0] idx_top;
    logic [IW-1:0] idx_below;
    logic [IW-1:0] idx_top_next;

    always_comb begin
        idx_push  = IW'(depth_q);
        idx_top   = IW'(depth_q - DW'(1));
        idx_below = IW'(depth_q - DW'(2));
    end

    // Next-state, stack update and error capture
    always_comb begin
        state_d    = state_q;
        stack_d    = stack_q;
        depth_d    = depth_q;
        err_code_d = err_code_q;
        calc_op_d  = 2'b00;
`ifdef RPN_OPCNT_EN
        op_count_d = op_count_q;
`endif

        case (state_q)
            IDLE: begin
                if (tok_valid && tok_ready_q) begin
                    if (tok_is_op) begin
                        if (depth_q < DW'(2)) begin
                            err_code_d = ERR_UDF;
                            state_d    = ERR;
                        end else begin
                            calc_op_d = tok_op;
                            state_d   = EXEC;
                        end
                    end else begin
                        if (depth_q == DW'(STACK_DEPTH)) begin
                            err_code_d = ERR_OVF;
                            state_d    = ERR;
                        end else begin
                            stack_d[idx_push] = tok_data;
                            depth_d           = depth_q + DW'(1);
                        end
                    end
                end
            end

            EXEC: begin
                if (calc_invalid) begin
                    err_code_d = ERR_DIV0;
                    state_d    = ERR;
                end else begin
                    // Pop two operands, push the result into the lower slot
                    stack_d[idx_below] = calc_result;
                    depth_d            = depth_q - DW'(1);
                    state_d            = IDLE;
`ifdef RPN_OPCNT_EN
                    op_count_d         = op_count_q + 16'd1;
`else
                    // op counter not built in this configuration
`endif
                end
            end

            ERR: begin
                if (clr) begin
                    err_code_d = ERR_NONE;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered-output values, all derived from the next state
    always_comb begin
        idx_top_next = IW'(depth_d - DW'(1));
        top_d        = '0;
        if (depth_d != '0) begin
            top_d = stack_d[idx_top_next];
        end

        // EXEC is only entered from IDLE, so the stack is unchanged on entry
        calc_a_d = '0;
        calc_b_d = '0;
        if (state_d == EXEC) begin
            calc_a_d = stack_q[idx_below];
            calc_b_d = stack_q[idx_top];
        end

        tok_ready_d = (state_d == IDLE);
        error_d     = (state_d == ERR);
    end

    // State and output registers; reset aborts any EXEC without a stack write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            stack_q     <= '{default: '0};
            depth_q     <= '0;
            top_q       <= '0;
            calc_a_q    <= '0;
            calc_b_q    <= '0;
            calc_op_q   <= 2'b00;
            err_code_q  <= ERR_NONE;
            error_q     <= 1'b0;
            tok_ready_q <= 1'b1;
`ifdef RPN_OPCNT_EN
            op_count_q  <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            stack_q     <= stack_d;
            depth_q     <= depth_d;
            top_q       <= top_d;
            calc_a_q    <= calc_a_d;
            calc_b_q    <= calc_b_d;
            calc_op_q   <= calc_op_d;
            err_code_q  <= err_code_d;
            error_q     <= error_d;
            tok_ready_q <= tok_ready_d;
`ifdef RPN_OPCNT_EN
            op_count_q  <= op_count_d;
`endif
        end
    end

    assign tok_ready = tok_ready_q;
    assign calc_a    = calc_a_q;
    assign calc_b    = calc_b_q;
    assign calc_op   = calc_op_q;
    assign top       = top_q;
    assign depth     = depth_q;
    assign error     = error_q;
    assign err_code  = err_code_q;
`ifdef RPN_OPCNT_EN
    assign op_count  = op_count_q;
`endif

endmodule
